// File: rtl/seq_game_ctrl.sv
// Memory-game sequencer: grows a random colour sequence, shows it, then checks the
// player's replies with timeouts, an optional single retry and live echo of presses.
module seq_game_ctrl #(
  parameter int CW             = 2,
  parameter int DEPTH          = 32,
  parameter int DISP_TICKS     = 12_500_000,
  parameter int GAP_TICKS      = 2_500_000,
  parameter int INPUT_TICKS    = 250_000_000,
  parameter int STEP_TICKS     = 500_000,
  parameter int MIN_DISP_TICKS = 2_500_000,
  localparam int TM_A = (DISP_TICKS > GAP_TICKS) ? DISP_TICKS : GAP_TICKS,
  localparam int TM_B = (INPUT_TICKS > TM_A) ? INPUT_TICKS : TM_A,
  localparam int TM_C = (STEP_TICKS > TM_B) ? STEP_TICKS : TM_B,
  localparam int TM_D = (MIN_DISP_TICKS > TM_C) ? MIN_DISP_TICKS : TM_C,
  localparam int TW   = $clog2(TM_D + 1),
  localparam int SW   = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [CW-1:0] IN,
  input  logic          IN_VALID,
  input  logic [CW-1:0] RAND,
  input  logic          START_GAME,
  input  logic          STRICT,
  output logic [CW-1:0] OUT,
  output logic          OUT_ENA,
  output logic          WIN,
  output logic          LOSE,
  output logic          HS,
  output logic [SW-1:0] SCORE,
  output logic [SW-1:0] HIGH_SCORE
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = TW + SW;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADD, S_SHOW, S_SHOW_WAIT, S_GAP, S_INPUT, S_HOLD, S_WIN, S_END
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] len, len_n, idx, idx_n, score_n, high_n;
  logic [TW-1:0] timer, timer_n, disp_ticks;
  logic [RW-1:0] step_total, disp_raw;
  logic [CW-1:0] out_n;
  logic          good, good_n, retry_avail, retry_n;
  logic          ena_n, win_n, lose_n, hs_n, push, expired, last;
  logic [CW-1:0] stack [DEPTH];

  // Display time shrinks per completed round, saturating at zero before the floor applies.
  always_comb begin
    step_total = RW'(STEP_TICKS) * RW'(SCORE);
    disp_raw   = (step_total >= RW'(DISP_TICKS)) ? '0 : RW'(DISP_TICKS) - step_total;
    disp_ticks = (disp_raw < RW'(MIN_DISP_TICKS)) ? TW'(MIN_DISP_TICKS) : disp_raw[TW-1:0];
  end

  assign expired = (timer == TW'(1));
  assign last    = (idx == len - SW'(1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      len         <= '0;
      idx         <= '0;
      timer       <= '0;
      good        <= 1'b0;
      retry_avail <= 1'b0;
      OUT         <= '1;
      OUT_ENA     <= 1'b0;
      WIN         <= 1'b0;
      LOSE        <= 1'b0;
      HS          <= 1'b0;
      SCORE       <= '0;
      HIGH_SCORE  <= '0;
    end else begin
      state       <= state_n;
      len         <= len_n;
      idx         <= idx_n;
      timer       <= timer_n;
      good        <= good_n;
      retry_avail <= retry_n;
      OUT         <= out_n;
      OUT_ENA     <= ena_n;
      WIN         <= win_n;
      LOSE        <= lose_n;
      HS          <= hs_n;
      SCORE       <= score_n;
      HIGH_SCORE  <= high_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) stack[len[IW-1:0]] <= RAND;
  end

  // IN_VALID is a level: a press is accepted on the first INPUT cycle it is seen high
  // and completes on the first HOLD cycle it is seen low; IN is sampled at acceptance.
  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = idx;
    timer_n = timer;
    good_n  = good;
    retry_n = retry_avail;
    out_n   = OUT;
    ena_n   = OUT_ENA;
    score_n = SCORE;
    high_n  = HIGH_SCORE;
    win_n   = 1'b0;
    lose_n  = 1'b0;
    hs_n    = 1'b0;
    push    = 1'b0;
    case (state)
      S_IDLE: begin
        idx_n = '0;
        len_n = '0;
        if (START_GAME) begin
          retry_n = !STRICT;
          state_n = S_START;
        end
      end
      S_START: begin
        if (!START_GAME) begin
          score_n = '0;
          state_n = S_ADD;
        end
      end
      S_ADD: begin
        push    = 1'b1;
        len_n   = len + SW'(1);
        idx_n   = '0;
        state_n = S_SHOW;
      end
      S_SHOW: begin
        out_n   = stack[idx[IW-1:0]];
        ena_n   = 1'b1;
        timer_n = disp_ticks;
        state_n = S_SHOW_WAIT;
      end
      S_SHOW_WAIT: begin
        if (expired) begin
          ena_n   = 1'b0;
          timer_n = TW'(GAP_TICKS);
          state_n = S_GAP;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      S_GAP: begin
        if (expired) begin
          if (last) begin
            idx_n   = '0;
            timer_n = TW'(INPUT_TICKS);
            state_n = S_INPUT;
          end else begin
            idx_n   = idx + SW'(1);
            state_n = S_SHOW;
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      S_INPUT: begin
        if (expired) begin
          lose_n  = 1'b1;
          hs_n    = (SCORE > HIGH_SCORE);
          state_n = S_END;
        end else if (IN_VALID) begin
          good_n  = (IN == stack[idx[IW-1:0]]);
          out_n   = IN;
          ena_n   = 1'b1;
          state_n = S_HOLD;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      S_HOLD: begin
        if (!IN_VALID) begin
          ena_n = 1'b0;
          if (good && last) begin
            score_n = len;
            if (len == SW'(DEPTH)) begin
              win_n   = 1'b1;
              state_n = S_WIN;
            end else begin
              state_n = S_ADD;
            end
          end else if (good) begin
            idx_n   = idx + SW'(1);
            timer_n = TW'(INPUT_TICKS);
            state_n = S_INPUT;
          end else if (retry_avail) begin
            retry_n = 1'b0;
            idx_n   = '0;
            state_n = S_SHOW;
          end else begin
            lose_n  = 1'b1;
            hs_n    = (SCORE > HIGH_SCORE);
            state_n = S_END;
          end
        end
      end
      S_WIN: begin
        hs_n    = (SCORE > HIGH_SCORE);
        state_n = S_END;
      end
      S_END: begin
        if (SCORE > HIGH_SCORE) high_n = SCORE;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_game_ctrl.sv
// Directed bench for seq_game_ctrl: table of whole games plus hand-written corner sequences.
module tb_seq_game_ctrl;

  localparam int CW    = 2;
  localparam int DEPTH = 4;
  localparam int SW    = 3;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [CW-1:0] IN, RAND, OUT;
  logic          IN_VALID, START_GAME, STRICT;
  logic          OUT_ENA, WIN, LOSE, HS;
  logic [SW-1:0] SCORE, HIGH_SCORE;

  seq_game_ctrl #(
    .CW(CW), .DEPTH(DEPTH), .DISP_TICKS(6), .GAP_TICKS(2), .INPUT_TICKS(20),
    .STEP_TICKS(2), .MIN_DISP_TICKS(3)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .IN(IN), .IN_VALID(IN_VALID), .RAND(RAND),
    .START_GAME(START_GAME), .STRICT(STRICT), .OUT(OUT), .OUT_ENA(OUT_ENA),
    .WIN(WIN), .LOSE(LOSE), .HS(HS), .SCORE(SCORE), .HIGH_SCORE(HIGH_SCORE)
  );

  // clock / cycle counter / pulse monitor
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int win_cnt = 0, lose_cnt = 0, hs_cnt = 0;
  int win_cyc = 0, lose_cyc = 0, hs_cyc = 0;
  always @(negedge CLK) begin
    if (WIN === 1'b1)  begin win_cnt  <= win_cnt + 1;  win_cyc  <= cyc; end
    if (LOSE === 1'b1) begin lose_cnt <= lose_cnt + 1; lose_cyc <= cyc; end
    if (HS === 1'b1)   begin hs_cnt   <= hs_cnt + 1;   hs_cyc   <= cyc; end
  end

  typedef struct {
    bit         strict;
    logic [1:0] seq [4];
    int         idle_round;
    int         err1;
    int         err2;
    bit         exp_win;
    bit         exp_lose;
    bit         exp_hs;
    int         exp_score;
    int         exp_high;
  } game_t;

  game_t      tbl [5];
  int         disp_w [4] = '{6, 4, 3, 3};
  logic [1:0] cur_seq [4];
  logic [1:0] exp_q [$];
  int         n_checks = 0, n_fail = 0;
  int         gap_cyc = 0;

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_game(input bit st, input logic [1:0] first);
    STRICT     = st;
    START_GAME = 1'b1;
    repeat (2) tick();
    RAND       = first;
    START_GAME = 1'b0;
  endtask

  task automatic show_colour(input logic [1:0] exp_col, input int exp_w, input string tag);
    int n = 0;
    int w = 0;
    do begin tick(); n++; end while (OUT_ENA !== 1'b1 && n < 60);
    check({tag, "_lit"}, OUT_ENA, 1);
    if (OUT_ENA === 1'b1) begin
      check({tag, "_col"}, OUT, exp_col);
      while (OUT_ENA === 1'b1 && w < 40) begin w++; tick(); end
      check({tag, "_width"}, w, exp_w);
      gap_cyc = cyc;
    end
  endtask

  task automatic show_round(input int r, input string tag);
    bit any = 1'b0;
    for (int k = 0; k < r; k++) exp_q.push_back(cur_seq[k]);
    for (int k = 0; k < r; k++)
      show_colour(exp_q.pop_front(), disp_w[r-1], $sformatf("%s_c%0d", tag, k));
    repeat (4) begin
      tick();
      if (OUT_ENA !== 1'b0) any = 1'b1;
    end
    check({tag, "_no_extra"}, any, 0);
  endtask

  task automatic press(input logic [1:0] col, input int hold, input logic [1:0] nxt,
                       input bit set_rand, input string tag);
    IN       = col;
    IN_VALID = 1'b1;
    repeat (hold) tick();
    check({tag, "_echo_ena"}, OUT_ENA, 1);
    check({tag, "_echo_col"}, OUT, col);
    if (set_rand) RAND = nxt;
    IN_VALID = 1'b0;
    tick();
    check({tag, "_echo_off"}, OUT_ENA, 0);
  endtask

  task automatic run_game(input int s);
    int    b_win, b_lose, b_hs, n, i, r;
    bit    lost, retry_left, e1, e2, wrong;
    string tag;
    b_win  = win_cnt;
    b_lose = lose_cnt;
    b_hs   = hs_cnt;
    cur_seq = tbl[s].seq;
    start_game(tbl[s].strict, cur_seq[0]);
    STRICT = !tbl[s].strict;
    lost = 1'b0; retry_left = 1'b1; e1 = 1'b0; e2 = 1'b0;
    r = 1;
    while (r <= DEPTH && !lost) begin
      tag = $sformatf("g%0d_r%0d", s, r);
      START_GAME = (r == 2);
      show_round(r, tag);
      START_GAME = 1'b0;
      if (r == tbl[s].idle_round) lost = 1'b1;
      i = 0;
      while (i < r && !lost) begin
        wrong = 1'b0;
        if (r == tbl[s].err1 && !e1 && i == 0) begin wrong = 1'b1; e1 = 1'b1; end
        else if (r == tbl[s].err2 && !e2 && i == r - 1) begin wrong = 1'b1; e2 = 1'b1; end
        if (wrong) begin
          press(cur_seq[i] ^ 2'b01, 3, cur_seq[r-1] ^ 2'b11, 1'b1, {tag, "_bad"});
          if (!tbl[s].strict && retry_left) begin
            retry_left = 1'b0;
            show_round(r, {tag, "_replay"});
            i = 0;
          end else begin
            lost = 1'b1;
          end
        end else begin
          press(cur_seq[i], 3, (r < DEPTH) ? cur_seq[r] : 2'b00, (i == r - 1), {tag, "_ok"});
          i++;
        end
      end
      r++;
    end
    n = 0;
    while ((win_cnt - b_win) + (lose_cnt - b_lose) == 0 && n < 80) begin tick(); n++; end
    check($sformatf("g%0d_end_seen", s), ((win_cnt - b_win) + (lose_cnt - b_lose)) != 0, 1);
    if (tbl[s].idle_round != 0)
      check($sformatf("g%0d_timeout_latency", s), lose_cyc - gap_cyc, 22);
    repeat (3) tick();
    check($sformatf("g%0d_win_cycles", s), win_cnt - b_win, tbl[s].exp_win);
    check($sformatf("g%0d_lose_cycles", s), lose_cnt - b_lose, tbl[s].exp_lose);
    check($sformatf("g%0d_hs_cycles", s), hs_cnt - b_hs, tbl[s].exp_hs);
    if (tbl[s].exp_hs)
      check($sformatf("g%0d_hs_in_end", s), hs_cyc, tbl[s].exp_win ? win_cyc + 1 : lose_cyc);
    check($sformatf("g%0d_score", s), SCORE, tbl[s].exp_score);
    check($sformatf("g%0d_high", s), HIGH_SCORE, tbl[s].exp_high);
    check($sformatf("g%0d_idle_dark", s), OUT_ENA, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_win, b_lose, b_hs, n;
    //     strict seq                          idle e1 e2 win lose hs score high
    tbl[0] = '{1'b1, '{2'd2, 2'd0, 2'd0, 2'd0}, 1, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[1] = '{1'b1, '{2'd1, 2'd3, 2'd0, 2'd2}, 0, 0, 0, 1'b1, 1'b0, 1'b1, 4, 4};
    tbl[2] = '{1'b0, '{2'd3, 2'd1, 2'd2, 2'd0}, 0, 2, 3, 1'b0, 1'b1, 1'b0, 2, 4};
    tbl[3] = '{1'b1, '{2'd0, 2'd2, 2'd1, 2'd3}, 0, 1, 0, 1'b0, 1'b1, 1'b0, 0, 4};
    tbl[4] = '{1'b0, '{2'd2, 2'd0, 2'd3, 2'd1}, 0, 1, 0, 1'b1, 1'b0, 1'b0, 4, 4};

    RST_N = 1'b0; IN = '0; IN_VALID = 1'b0; RAND = '0; START_GAME = 1'b0; STRICT = 1'b0;
    repeat (3) tick();
    check("rst_out", OUT, 3);
    check("rst_ena", OUT_ENA, 0);
    check("rst_win", WIN, 0);
    check("rst_lose", LOSE, 0);
    check("rst_hs", HS, 0);
    check("rst_score", SCORE, 0);
    check("rst_high", HIGH_SCORE, 0);
    RST_N = 1'b1;
    repeat (2) tick();

    for (int s = 0; s < 5; s++) run_game(s);

    // timeout expiring in the same cycle as a press: lose, no echo
    b_lose = lose_cnt;
    start_game(1'b1, 2'd1);
    show_colour(2'd1, 6, "to_c0");
    n = 0;
    while (cyc < gap_cyc + 21 && n < 40) begin tick(); n++; end
    IN = 2'd1; IN_VALID = 1'b1;
    tick();
    check("to_lose_now", LOSE, 1);
    check("to_no_echo", OUT_ENA, 0);
    IN_VALID = 1'b0;
    repeat (3) tick();
    check("to_lose_cycles", lose_cnt - b_lose, 1);
    check("to_score", SCORE, 0);
    check("to_high", HIGH_SCORE, 4);

    // button held far past the input timeout, then reset in the middle of a display
    b_win = win_cnt; b_lose = lose_cnt; b_hs = hs_cnt;
    start_game(1'b1, 2'd2);
    show_colour(2'd2, 6, "hold_c0");
    repeat (3) tick();
    press(2'd2, 100, 2'd1, 1'b1, "hold");
    check("hold_no_timeout", lose_cnt - b_lose, 0);
    n = 0;
    do begin tick(); n++; end while (OUT_ENA !== 1'b1 && n < 60);
    check("pre_rst_ena", OUT_ENA, 1);
    check("pre_rst_col", OUT, 2);
    check("pre_rst_score", SCORE, 1);
    check("pre_rst_high", HIGH_SCORE, 4);
    RST_N = 1'b0;
    #1;
    check("mid_rst_out", OUT, 3);
    check("mid_rst_ena", OUT_ENA, 0);
    check("mid_rst_win", WIN, 0);
    check("mid_rst_lose", LOSE, 0);
    check("mid_rst_hs", HS, 0);
    check("mid_rst_score", SCORE, 0);
    check("mid_rst_high", HIGH_SCORE, 0);
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (3) tick();
    check("post_rst_pulses", (win_cnt - b_win) + (lose_cnt - b_lose) + (hs_cnt - b_hs), 0);
    check("post_rst_ena", OUT_ENA, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_game_ctrl.md
Name: seq_game_ctrl

Overview:
Parametrised successor to the four-colour memory-game controller. It supports N-bit colour codes, a configurable sequence depth, per-round display speed-up, a one-time retry mode and live input echo. It contains its own down-counter timer, so no external timer instance is needed. It sits between the button debouncer/LFSR and the LED/sound drivers.

Parameters:
CW, 2, colour code width (2**CW colours)
DEPTH, 32, maximum sequence length; completing DEPTH rounds is a win
DISP_TICKS, 12_500_000, round-1 colour display time in cycles
GAP_TICKS, 2_500_000, dark gap between displayed colours, in cycles
INPUT_TICKS, 250_000_000, per-press response timeout, in cycles
STEP_TICKS, 500_000, display-time reduction per completed round
MIN_DISP_TICKS, 2_500_000, floor on display time
(Derived: TW = $clog2(max of tick params + 1); SW = $clog2(DEPTH + 1).)

Ports:
CLK  in  1  system clock
RST_N  in  1  reset, asynchronous, active-low
IN  in  CW  debounced player colour
IN_VALID  in  1  player button held
RAND  in  CW  random colour, sampled only in ADD
START_GAME  in  1  start request (press/release)
STRICT  in  1  1 = no retry; sampled on IDLE->START
OUT  out  CW  colour to LED/sound
OUT_ENA  out  1  OUT is active
WIN  out  1  one-cycle pulse, all DEPTH rounds done
LOSE  out  1  one-cycle pulse, game lost
HS  out  1  one-cycle pulse, new high score
SCORE  out  SW  completed rounds of current/last game
HIGH_SCORE  out  SW  best SCORE since reset

Behaviour:
- Reset values (async, immediate): state=IDLE; OUT=all-ones; all other outputs 0; len, idx, timer 0; retry_avail=0; stack contents undefined.
- Timer: load N means the waiting state lasts exactly N cycles; expiry is flagged in the cycle the count reaches 1.
- disp_ticks = max(MIN_DISP_TICKS, DISP_TICKS - STEP_TICKS*SCORE). Compute it with saturating arithmetic: no underflow wrap.
- IDLE: idx=0, len=0. On START_GAME=1, go to START; latch strict and set retry_avail = !STRICT.
- START: on START_GAME=0, clear SCORE and go to ADD.
- ADD: stack[len] <= RAND; len <= len+1; idx <= 0; go to SHOW.
- SHOW (1 cycle): OUT <= stack[idx]; OUT_ENA <= 1; load disp_ticks; go to SHOW_WAIT.
- SHOW_WAIT: on expiry, OUT_ENA <= 0, load GAP_TICKS, go to GAP.
- GAP: on expiry:
  - if idx == len-1: idx <= 0, load INPUT_TICKS, go to INPUT;
  - else idx <= idx+1, go to SHOW.
- INPUT:
  - Timeout: go to END (lose). Timeout has priority over a simultaneous IN_VALID.
  - Otherwise on IN_VALID: good <= (IN == stack[idx]); OUT <= IN; OUT_ENA <= 1 (echo); go to HOLD.
- HOLD: the timer is frozen, with no timeout while held. On IN_VALID=0, OUT_ENA <= 0, then:
  - good and idx == len-1: SCORE <= len. If len == DEPTH go to WIN, else go to ADD.
  - good otherwise: idx <= idx+1; load INPUT_TICKS; go to INPUT.
  - bad and retry_avail: retry_avail <= 0; idx <= 0; go to SHOW. This replays the same sequence with no new colour.
  - bad otherwise: go to END (lose).
- WIN: WIN pulse; go to END with won=1.
- END (1 cycle):
  - LOSE pulse if !won.
  - If SCORE > HIGH_SCORE: HIGH_SCORE <= SCORE and HS pulse (same cycle).
  - Go to IDLE.
- Holding and ignores:
  - SCORE and HIGH_SCORE hold until the next START->ADD and until reset, respectively.
  - START_GAME outside IDLE/START is ignored.
  - STRICT changes mid-game are ignored.
- Illegal state: go to IDLE next cycle, outputs unchanged.
- RST_N low mid-game aborts immediately. HIGH_SCORE clears; no WIN/LOSE/HS pulse is emitted.

Test Plan:
Bench overrides: CW=2, DEPTH=4, DISP_TICKS=6, GAP_TICKS=2, INPUT_TICKS=20, STEP_TICKS=2, MIN_DISP_TICKS=3.
1. Start pulse, RAND=2, idle player -> OUT=2 with OUT_ENA high exactly 6 cycles. 20 cycles after GAP ends: LOSE=1 for 1 cycle, HS=0, SCORE=0.
2. Perfect play with RAND sequence 1,3,0,2 -> OUT_ENA widths 6,4,3,3 in rounds 1-4. Then WIN=1 for 1 cycle, LOSE=0, SCORE=4, HIGH_SCORE=4, HS=1 in the END cycle.
3. STRICT=0, round 2, wrong colour pressed and released -> sequence replayed (2 colours, no new RAND sample). A correct reply advances to round 3. A second wrong press -> LOSE pulse, SCORE=2.
4. STRICT=1, wrong press in round 1 -> echo OUT=IN while held. On release, LOSE pulse with SCORE=0, and no replay.
5. Second game scoring 2 after a high score of 4 -> HS stays 0 and HIGH_SCORE=4. Then assert RST_N low mid-SHOW -> all outputs at reset values on the same edge, HIGH_SCORE=0.
6. IN_VALID asserted in the same cycle the input timeout expires -> LOSE, no HOLD entry. A button held 100 cycles (longer than INPUT_TICKS) in HOLD -> no timeout; release with the correct colour continues.
